sprite_scanner: RTL and testbench

Per-scanline sprite evaluation controller for the PPU sprite engine. On each scan request it walks all 128 OAM entries through the OAM read wrapper, one read per cycle, and tests each sprite's vertical extent against the requested scanline. Hits are written in OAM order into the line sprite buffer consumed by the sprite pixel pipeline. It is the sole requester of the OAM read port during a scan.

---
 rtl/sprite_scanner.sv | 187 ++++++++++++++++++
 tb/tb_sprite_scanner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scanner.sv
// ============================================================================
//  Module   : sprite_scanner (with sprite_pkg)
//  Purpose  : Per-scanline sprite evaluation. On scan_start, walks every OAM
//             entry through the OAM read wrapper (one read per cycle), tests
//             each sprite's vertical extent against the requested scanline,
//             and writes hits in OAM order into the line sprite buffer.
//  Ports    : clock, reset            - clock / synchronous active-high reset
//             scan_start, scan_line   - scan request and target scanline
//             scan_busy, scan_done    - scan in progress / completion pulse
//             sprite_count            - sprites written during this scan
//             sprite_overflow         - more hits than the buffer holds
//             oam_addr, oam_read      - OAM read request
//             oam_avail, oam_data     - OAM read response (one cycle later)
//             buf_we, buf_addr,
//             buf_wrdata, buf_index   - line sprite buffer write port
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;
    typedef struct packed {
        logic [7:0] y;     // top scanline of the sprite
        logic [7:0] x;     // horizontal position
        logic [7:0] tile;  // tile number
        logic [5:0] attr;  // palette / flip / priority attributes
        logic [1:0] size;  // height = 8 << size
    } sprite_conf_t;
endpackage

module sprite_scanner
    import sprite_pkg::*;
#(
    parameter int MAX_SPRITES = 32,
    parameter int NUM_OAM     = 128
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           scan_start,
    input  logic [7:0]                     scan_line,
    output logic                           scan_busy,
    output logic                           scan_done,
    output logic [$clog2(MAX_SPRITES):0]   sprite_count,
    output logic                           sprite_overflow,
    output logic [6:0]                     oam_addr,
    output logic                           oam_read,
    input  logic                           oam_avail,
    input  sprite_conf_t                   oam_data,
    output logic                           buf_we,
    output logic [$clog2(MAX_SPRITES)-1:0] buf_addr,
    output sprite_conf_t                   buf_wrdata,
    output logic [6:0]                     buf_index
);

    localparam int c_ADDR_W = $clog2(MAX_SPRITES);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_SPRITES);
    localparam logic [6:0]         c_LAST_IDX = 7'(NUM_OAM - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SCAN  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [7:0]         r_line;
    logic [6:0]         r_index;
    logic [6:0]         r_ret_index;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;

    logic               w_accept;
    logic               w_eval;
    logic [7:0]         w_diff;
    logic [8:0]         w_height;
    logic               w_hit;
    logic               w_full;
    logic               w_write;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        oam_read    = 1'b0;
        oam_addr    = 7'd0;
        scan_busy   = 1'b0;
        scan_done   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (scan_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_SCAN;
                end
            end
            c_SCAN: begin
                oam_read  = 1'b1;
                oam_addr  = r_index;
                scan_busy = 1'b1;
                if (r_index == c_LAST_IDX) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                // last read is returning this cycle
                scan_busy   = 1'b1;
                w_state_nxt = c_DONE;
            end
            c_DONE: begin
                scan_done   = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hit test on returning OAM data. Responses are only honoured while a
    // scan is in flight, so a read outstanding across a reset is dropped.
    // The 8-bit modular difference makes sprites wrap past line 255.
    // ------------------------------------------------------------------
    assign w_eval   = oam_avail && ((r_state == c_SCAN) || (r_state == c_DRAIN));
    assign w_diff   = r_line - oam_data.y;
    assign w_height = 9'd8 << oam_data.size;
    assign w_hit    = w_eval && ({1'b0, w_diff} < w_height);
    assign w_full   = (r_count == c_MAX_CNT);
    assign w_write  = w_hit && !w_full;

    assign buf_we     = w_write;
    assign buf_addr   = w_write ? r_count[c_ADDR_W-1:0] : '0;
    assign buf_wrdata = w_write ? oam_data : '0;
    assign buf_index  = w_write ? r_ret_index : 7'd0;

    assign sprite_count    = r_count;
    assign sprite_overflow = r_overflow;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_line      <= 8'd0;
            r_index     <= 7'd0;
            r_ret_index <= 7'd0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_line     <= scan_line;
                r_index    <= 7'd0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end
            if (r_state == c_SCAN) begin
                r_index <= r_index + 7'd1;
            end
            // index of the entry whose data arrives next cycle
            if (oam_read) begin
                r_ret_index <= oam_addr;
            end
            if (w_write) begin
                r_count <= r_count + c_CNT_W'(1);
            end
            if (w_hit && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_scanner.sv
// ============================================================================
//  Module   : tb_sprite_scanner
//  Purpose  : Directed self-checking bench for sprite_scanner with a simple
//             one-cycle-latency OAM model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_scanner;
    import sprite_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         scan_start = 1'b0;
    logic [7:0]   scan_line = 8'd0;
    logic         scan_busy;
    logic         scan_done;
    logic [5:0]   sprite_count;
    logic         sprite_overflow;
    logic [6:0]   oam_addr;
    logic         oam_read;
    logic         oam_avail = 1'b0;
    sprite_conf_t oam_data = '0;
    logic         buf_we;
    logic [4:0]   buf_addr;
    sprite_conf_t buf_wrdata;
    logic [6:0]   buf_index;

    int total = 0;
    int bad   = 0;

    sprite_conf_t mem [128];

    int           q_rel  [$];
    int           q_addr [$];
    int           q_idx  [$];
    sprite_conf_t q_dat  [$];
    int           exp_q  [$];

    sprite_scanner #(.MAX_SPRITES(32), .NUM_OAM(128)) dut (
        .clock           (clock),
        .reset           (reset),
        .scan_start      (scan_start),
        .scan_line       (scan_line),
        .scan_busy       (scan_busy),
        .scan_done       (scan_done),
        .sprite_count    (sprite_count),
        .sprite_overflow (sprite_overflow),
        .oam_addr        (oam_addr),
        .oam_read        (oam_read),
        .oam_avail       (oam_avail),
        .oam_data        (oam_data),
        .buf_we          (buf_we),
        .buf_addr        (buf_addr),
        .buf_wrdata      (buf_wrdata),
        .buf_index       (buf_index)
    );

    always #5 clock = ~clock;

    // OAM wrapper model: data valid exactly one cycle after the read strobe
    always @(posedge clock) begin
        oam_avail <= oam_read;
        oam_data  <= mem[oam_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic sprite_conf_t mk(input int y, input int size, input int idx);
        sprite_conf_t s;
        s.y    = 8'(y);
        s.x    = 8'(idx);
        s.tile = 8'(idx) ^ 8'hA5;
        s.attr = 6'h2A;
        s.size = 2'(size);
        return s;
    endfunction

    task automatic fill(input int y, input int size);
        for (int i = 0; i < 128; i++) mem[i] = mk(y, size, i);
    endtask

    // One full scan; checks timing, read sequence, results and buffer writes.
    task automatic run_scan(input logic [7:0] line, input bit pulse10, input bit pulse_done,
                            input int exp_cnt, input bit exp_ovf, input string tag);
        int rel, done_rel, nreads, busy_bad, addr_bad;
        logic [5:0] cnt_at_done;
        logic       ovf_at_done;
        q_rel.delete(); q_addr.delete(); q_idx.delete(); q_dat.delete();
        cnt_at_done = '1;
        ovf_at_done = 1'bx;
        @(negedge clock);
        scan_start = 1'b1;
        scan_line  = line;
        @(negedge clock);
        scan_start = 1'b0;
        scan_line  = 8'hEE;
        rel = 1; done_rel = -1; nreads = 0; busy_bad = 0; addr_bad = 0;
        chk({tag, "/first_read"}, {56'd0, oam_read, oam_addr}, {56'd0, 1'b1, 7'd0});
        while (rel <= 200) begin
            scan_start = 1'b0;
            if (buf_we) begin
                q_rel.push_back(rel);
                q_addr.push_back(int'(buf_addr));
                q_idx.push_back(int'(buf_index));
                q_dat.push_back(buf_wrdata);
            end
            if (oam_read) begin
                if (oam_addr !== 7'(nreads)) addr_bad++;
                nreads++;
            end
            if (scan_done) begin
                done_rel    = rel;
                cnt_at_done = sprite_count;
                ovf_at_done = sprite_overflow;
                break;
            end
            if (scan_busy !== 1'b1) busy_bad++;
            if (pulse10 && rel == 10) scan_start = 1'b1;
            @(negedge clock);
            rel++;
        end
        chk({tag, "/done_cycle"}, 64'(done_rel), 64'd130);
        chk({tag, "/reads"}, 64'(nreads), 64'd128);
        chk({tag, "/addr_seq_errs"}, 64'(addr_bad), 64'd0);
        chk({tag, "/busy_errs"}, 64'(busy_bad), 64'd0);
        chk({tag, "/count"}, {58'd0, cnt_at_done}, 64'(exp_cnt));
        chk({tag, "/overflow"}, {63'd0, ovf_at_done}, {63'd0, exp_ovf});
        chk({tag, "/nwrites"}, 64'(q_rel.size()), 64'(exp_q.size()));
        for (int i = 0; i < q_rel.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s/wr%0d_cycle", tag, i), 64'(q_rel[i]), 64'(exp_q[i] + 2));
            chk($sformatf("%s/wr%0d_slot", tag, i), 64'(q_addr[i]), 64'(i));
            chk($sformatf("%s/wr%0d_index", tag, i), 64'(q_idx[i]), 64'(exp_q[i]));
            chk($sformatf("%s/wr%0d_data", tag, i), 64'(q_dat[i]), 64'(mem[exp_q[i]]));
        end
        if (pulse_done) begin
            scan_start = 1'b1;
            scan_line  = 8'd0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                scan_start = 1'b0;
                chk($sformatf("%s/post_busy%0d", tag, c), {63'd0, scan_busy}, 64'd0);
                chk($sformatf("%s/post_read%0d", tag, c), {63'd0, oam_read}, 64'd0);
            end
        end
    endtask

    initial begin
        fill(200, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset/busy",     {63'd0, scan_busy},       64'd0);
        chk("reset/done",     {63'd0, scan_done},       64'd0);
        chk("reset/count",    {58'd0, sprite_count},    64'd0);
        chk("reset/overflow", {63'd0, sprite_overflow}, 64'd0);
        chk("reset/oam",      {56'd0, oam_read, oam_addr}, 64'd0);
        chk("reset/buf",      {51'd0, buf_we, buf_addr, buf_index}, 64'd0);
        reset = 1'b0;

        // basic hits: sprite 3 (diff 4) and sprite 9 (diff 7)
        fill(200, 0);
        mem[3] = mk(16, 0, 3);
        mem[9] = mk(13, 0, 9);
        exp_q = '{3, 9};
        run_scan(8'd20, 1'b0, 1'b0, 2, 1'b0, "basic");

        // boundaries and vertical wrap
        fill(200, 0);
        mem[0] = mk(16, 0, 0);
        mem[1] = mk(16, 1, 1);
        mem[2] = mk(0, 3, 2);
        mem[4] = mk(250, 1, 4);
        mem[5] = mk(250, 0, 5);
        exp_q = '{1, 2};
        run_scan(8'd24, 1'b0, 1'b0, 2, 1'b0, "line24");
        exp_q = '{2};
        run_scan(8'd63, 1'b0, 1'b0, 1, 1'b0, "line63");
        exp_q = {};
        run_scan(8'd64, 1'b0, 1'b0, 0, 1'b0, "line64");
        exp_q = '{2, 4};
        run_scan(8'd5, 1'b0, 1'b0, 2, 1'b0, "wrap5");
        exp_q = '{2};
        run_scan(8'd10, 1'b0, 1'b0, 1, 1'b0, "wrap10");

        // every sprite hits: reset mid-scan, then an overflowing scan
        fill(0, 3);
        @(negedge clock);
        scan_start = 1'b1;
        scan_line  = 8'd0;
        @(negedge clock);
        scan_start = 1'b0;
        repeat (49) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst/busy",  {63'd0, scan_busy},    64'd0);
        chk("midrst/we",    {63'd0, buf_we},       64'd0);
        chk("midrst/count", {58'd0, sprite_count}, 64'd0);
        chk("midrst/oam",   {56'd0, oam_read, oam_addr}, 64'd0);
        @(negedge clock);
        chk("midrst/idle_read", {63'd0, oam_read}, 64'd0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(i);
        run_scan(8'd0, 1'b0, 1'b0, 32, 1'b1, "overflow");

        // busy handshake: stray starts mid-scan and in DONE are ignored
        fill(200, 0);
        mem[3] = mk(16, 0, 3);
        mem[9] = mk(13, 0, 9);
        exp_q = '{3, 9};
        run_scan(8'd20, 1'b1, 1'b1, 2, 1'b0, "handshake");

        // back-to-back scans, second start at the edge ending T+131
        run_scan(8'd20, 1'b0, 1'b0, 2, 1'b0, "b2b_a");
        run_scan(8'd20, 1'b0, 1'b0, 2, 1'b0, "b2b_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
